// File: rtl/pe_sched_pkg.sv
// Shared constants and types for the PE dispatch scheduler.
// Sizes the PE index, credit counters and instruction words.
package pe_sched_pkg;

    localparam int NUM_PE   = 14;
    localparam int PE_IDX_W = 4;
    localparam int INST_W   = 16;
    localparam int MAX_CRED = 2;
    localparam int CRED_W   = 3;

    typedef logic [PE_IDX_W-1:0] pe_idx_t;
    typedef logic [CRED_W-1:0]   cred_t;

endpackage

// File: rtl/pe_dispatch_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins.
// Purely combinational; produces a one-hot grant and its index.
module rr_arbiter
    import pe_sched_pkg::*;
(
    input  logic [NUM_PE-1:0] i_req,
    input  pe_idx_t           i_ptr,
    output logic [NUM_PE-1:0] o_gnt,
    output pe_idx_t           o_idx,
    output logic              o_any
);

    int      w_j;
    pe_idx_t w_p;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        w_p   = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_PE;
            w_p = pe_idx_t'(w_j);
            if (!o_any && i_req[w_p]) begin
                o_any      = 1'b1;
                o_gnt[w_p] = 1'b1;
                o_idx      = w_p;
            end
        end
    end

endmodule

// File: rtl/pe_dispatch_scheduler.sv
// Shares one packetizer path among the per-PE instruction FIFOs,
// gating each dispatch on a per-PE credit replenished by ack tokens.
module pe_dispatch_scheduler
    import pe_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PE-1:0]        req_valid,
    input  logic [NUM_PE*INST_W-1:0] req_inst,
    output logic [NUM_PE-1:0]        req_ready,
    input  logic                     ack_valid,
    input  pe_idx_t                  ack_pe,
    output logic                     out_valid,
    output logic [INST_W-1:0]        out_inst,
    output pe_idx_t                  out_pe,
    input  logic                     out_ready,
    output logic                     idle,
    output logic                     ack_err
);

    cred_t             r_cred [NUM_PE];
    pe_idx_t           r_rr_ptr;
    logic              r_out_valid;
    logic [INST_W-1:0] r_out_inst;
    pe_idx_t           r_out_pe;
    logic              r_ack_err;

    logic [NUM_PE-1:0] w_elig;
    logic [NUM_PE-1:0] w_req;
    logic [NUM_PE-1:0] w_gnt;
    logic [NUM_PE-1:0] w_inc;
    pe_idx_t           w_idx;
    logic              w_any;
    logic              w_slot_free;
    logic              w_ack_inrange;
    logic              w_ack_full;
    logic              w_ack_ok;
    logic              w_all_full;

    // Eligibility uses registered credit only, so acks never reach req_ready.
    always_comb begin
        w_elig     = '0;
        w_ack_full = 1'b0;
        w_all_full = 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin
            w_elig[i] = req_valid[i] && (r_cred[i] != '0);
            if (ack_pe == pe_idx_t'(i) && r_cred[i] == cred_t'(MAX_CRED))
                w_ack_full = 1'b1;
            if (r_cred[i] != cred_t'(MAX_CRED))
                w_all_full = 1'b0;
        end
    end

    assign w_slot_free   = !r_out_valid || out_ready;
    assign w_req         = w_elig & {NUM_PE{w_slot_free}};
    assign w_ack_inrange = int'(ack_pe) < NUM_PE;
    assign w_ack_ok      = ack_valid && w_ack_inrange && !w_ack_full;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_PE; i++)
            w_inc[i] = w_ack_ok && (ack_pe == pe_idx_t'(i));
    end

    rr_arbiter u_arb (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PE; i++)
                r_cred[i] <= cred_t'(MAX_CRED);
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (w_gnt[i] && !w_inc[i])
                    r_cred[i] <= r_cred[i] - 1'b1;
                else if (w_inc[i] && !w_gnt[i])
                    r_cred[i] <= r_cred[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pe    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_any) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= req_inst[int'(w_idx)*INST_W +: INST_W];
            r_out_pe    <= w_idx;
            r_rr_ptr    <= (w_idx == pe_idx_t'(NUM_PE-1)) ? '0 : w_idx + 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ack_err <= 1'b0;
        else if (ack_valid && !w_ack_ok)
            r_ack_err <= 1'b1;
    end

    assign req_ready = w_gnt;
    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_pe    = r_out_pe;
    assign ack_err   = r_ack_err;
    assign idle      = w_all_full && !r_out_valid;

endmodule

// File: tb/tb_pe_dispatch_scheduler.sv
// Bench for pe_dispatch_scheduler: directed scenarios plus random
// traffic, all checked against a credit/round-robin reference model.
module tb_pe_dispatch_scheduler;

    localparam int NPE  = 14;
    localparam int IW   = 16;
    localparam int MAXC = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NPE-1:0]     req_valid;
    logic [NPE*IW-1:0]  req_inst;
    logic [NPE-1:0]     req_ready;
    logic               ack_valid;
    logic [3:0]         ack_pe;
    logic               out_valid;
    logic [IW-1:0]      out_inst;
    logic [3:0]         out_pe;
    logic               out_ready;
    logic               idle;
    logic               ack_err;

    int errors = 0;
    int checks = 0;

    int            m_cred [NPE];
    int            m_ptr;
    bit            m_ov;
    logic [IW-1:0] m_inst;
    int            m_pe;
    bit            m_err;

    pe_dispatch_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_inst  (req_inst),
        .req_ready (req_ready),
        .ack_valid (ack_valid),
        .ack_pe    (ack_pe),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pe    (out_pe),
        .out_ready (out_ready),
        .idle      (idle),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    function automatic int m_pick();
        if (m_ov && !out_ready) return -1;
        for (int k = 0; k < NPE; k++) begin
            int p = (m_ptr + k) % NPE;
            if (req_valid[p] && m_cred[p] > 0) return p;
        end
        return -1;
    endfunction

    function automatic logic [NPE-1:0] m_ready();
        logic [NPE-1:0] r;
        int g;
        r = '0;
        g = m_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic bit m_idle();
        for (int i = 0; i < NPE; i++)
            if (m_cred[i] != MAXC) return 1'b0;
        return !m_ov;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NPE; i++) m_cred[i] = MAXC;
        m_ptr = 0; m_ov = 0; m_inst = '0; m_pe = 0; m_err = 0;
    endfunction

    function automatic void m_tick();
        int g;
        bit ok;
        if (rst) begin
            m_reset();
            return;
        end
        g  = m_pick();
        ok = ack_valid && (ack_pe < NPE) && (m_cred[ack_pe] < MAXC);
        if (ack_valid && !ok) m_err = 1;
        if (ok) m_cred[ack_pe]++;
        if (g >= 0) begin
            m_cred[g]--;
            m_inst = req_inst[g*IW +: IW];
            m_pe   = g;
            m_ov   = 1;
            m_ptr  = (g + 1) % NPE;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endfunction

    task automatic step();
        m_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = '0;
        ack_valid = 1'b0;
        ack_pe    = '0;
        out_ready = 1'b1;
    endtask

    task automatic rand_inst();
        for (int i = 0; i < NPE; i++) req_inst[i*IW +: IW] = 16'($urandom);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic restore();
        drive_idle();
        for (int n = 0; n < 40; n++) begin
            int p = -1;
            for (int i = 0; i < NPE; i++)
                if (p < 0 && m_cred[i] < MAXC) p = i;
            if (p < 0) break;
            ack_valid = 1'b1;
            ack_pe    = 4'(p);
            step();
        end
        ack_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rand_inst();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_inst !== '0 || out_pe !== '0) begin
            errors++; $display("FAIL reset_out_data got=%h/%0d exp=0/0", out_inst, out_pe);
        end
        checks++;
        if (idle !== 1'b1 || ack_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags idle=%b ack_err=%b exp=1/0", idle, ack_err);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [IW-1:0] exp_inst;
        drive_idle();
        rand_inst();
        req_valid = '1;
        for (int c = 0; c < 2*NPE; c++) begin
            #1;
            checks++;
            if (req_ready !== m_ready() || req_ready !== NPE'(1 << (c % NPE))) begin
                errors++;
                $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, m_ready());
            end
            exp_inst = req_inst[(c % NPE)*IW +: IW];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pe !== 4'(c % NPE) || out_inst !== exp_inst) begin
                errors++;
                $display("FAIL rr_out c=%0d got=%b/%0d/%h exp=1/%0d/%h",
                         c, out_valid, out_pe, out_inst, c % NPE, exp_inst);
            end
        end
        #1;
        checks++;
        if (req_ready !== '0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL rr_exhausted ready=%b idle=%b exp=0/0", req_ready, idle);
        end
        restore();
        checks++;
        if (idle !== m_idle() || idle !== 1'b1) begin
            errors++; $display("FAIL rr_restore_idle got=%b exp=1", idle);
        end
    endtask

    task automatic test_credit_limit();
        int cnt = 0;
        drive_idle();
        rand_inst();
        req_valid = NPE'(1 << 5);
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req_ready[5]) cnt++;
            checks++;
            if (req_ready !== m_ready()) begin
                errors++;
                $display("FAIL cred_ready c=%0d got=%b exp=%b", c, req_ready, m_ready());
            end
            step();
            checks++;
            if (out_valid !== m_ov || out_pe !== 4'(m_pe)) begin
                errors++;
                $display("FAIL cred_out c=%0d got=%b/%0d exp=%b/%0d",
                         c, out_valid, out_pe, m_ov, m_pe);
            end
        end
        checks++;
        if (cnt != MAXC) begin
            errors++; $display("FAIL cred_count got=%0d exp=%0d", cnt, MAXC);
        end
        ack_valid = 1'b1;
        ack_pe    = 4'd5;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL cred_ack_same_cycle got=%b exp=0", req_ready);
        end
        step();
        ack_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== NPE'(1 << 5)) begin
            errors++; $display("FAIL cred_ack_regrant got=%b exp=%b", req_ready, NPE'(1 << 5));
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pe !== 4'd5) begin
            errors++; $display("FAIL cred_ack_dispatch got=%b/%0d exp=1/5", out_valid, out_pe);
        end
        restore();
    endtask

    task automatic test_stall();
        drive_idle();
        rand_inst();
        req_valid = NPE'(1 << 2);
        req_inst[2*IW +: IW] = 16'hA5A5;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 16'hA5A5 || out_pe !== 4'd2) begin
            errors++;
            $display("FAIL stall_load got=%b/%h/%0d exp=1/a5a5/2", out_valid, out_inst, out_pe);
        end
        out_ready = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, req_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_inst !== 16'hA5A5 || out_pe !== 4'd2) begin
                errors++;
                $display("FAIL stall_hold c=%0d got=%b/%h/%0d exp=1/a5a5/2",
                         c, out_valid, out_inst, out_pe);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== NPE'(1 << 3) || req_ready !== m_ready()) begin
            errors++; $display("FAIL stall_resume got=%b exp=%b", req_ready, NPE'(1 << 3));
        end
        step();
        restore();
    endtask

    task automatic test_same_cycle();
        drive_idle();
        rand_inst();
        req_valid = NPE'(1 << 3);
        step();
        ack_valid = 1'b1;
        ack_pe    = 4'd3;
        #1;
        checks++;
        if (req_ready !== NPE'(1 << 3)) begin
            errors++; $display("FAIL same_grant got=%b exp=%b", req_ready, NPE'(1 << 3));
        end
        step();
        ack_valid = 1'b0;
        checks++;
        if (ack_err !== 1'b0 || ack_err !== m_err) begin
            errors++; $display("FAIL same_ack_err got=%b exp=0", ack_err);
        end
        #1;
        checks++;
        if (req_ready !== NPE'(1 << 3)) begin
            errors++; $display("FAIL same_cred_one got=%b exp=%b", req_ready, NPE'(1 << 3));
        end
        step();
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL same_cred_zero got=%b exp=0", req_ready);
        end
        restore();
    endtask

    task automatic test_illegal_ack();
        int cnt = 0;
        do_reset();
        ack_valid = 1'b1;
        ack_pe    = 4'd14;
        step();
        ack_valid = 1'b0;
        checks++;
        if (ack_err !== 1'b1 || idle !== 1'b1) begin
            errors++; $display("FAIL ill_range ack_err=%b idle=%b exp=1/1", ack_err, idle);
        end
        do_reset();
        ack_valid = 1'b1;
        ack_pe    = 4'd0;
        step();
        ack_valid = 1'b0;
        checks++;
        if (ack_err !== 1'b1 || idle !== 1'b1) begin
            errors++; $display("FAIL ill_full ack_err=%b idle=%b exp=1/1", ack_err, idle);
        end
        req_valid = NPE'(1);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (req_ready[0]) cnt++;
            step();
        end
        checks++;
        if (cnt != MAXC) begin
            errors++; $display("FAIL ill_full_cred got=%0d exp=%0d", cnt, MAXC);
        end
        restore();
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        do_reset();
        rand_inst();
        req_valid = NPE'(1 << 7);
        step();
        step();
        req_valid = '0;
        out_ready = 1'b0;
        ack_valid = 1'b1;
        ack_pe    = 4'd15;
        step();
        ack_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ack_err !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup got=%b/%b/%b exp=1/1/0", out_valid, ack_err, idle);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || idle !== 1'b1 || ack_err !== 1'b0 ||
            out_pe !== '0 || out_inst !== '0) begin
            errors++;
            $display("FAIL mid_reset got=%b/%b/%b/%0d/%h exp=0/1/0/0/0",
                     out_valid, idle, ack_err, out_pe, out_inst);
        end
        out_ready = 1'b1;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== NPE'(1)) begin
            errors++; $display("FAIL mid_ptr got=%b exp=%b", req_ready, NPE'(1));
        end
        step();
        req_valid = NPE'(1 << 7);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (req_ready[7]) cnt++;
            step();
        end
        checks++;
        if (cnt != MAXC) begin
            errors++; $display("FAIL mid_cred7 got=%0d exp=%0d", cnt, MAXC);
        end
        restore();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_inst();
            rst       = (c == 300) || ($urandom % 150 == 0);
            req_valid = NPE'($urandom);
            out_ready = ($urandom % 4) != 0;
            ack_valid = ($urandom % 2) == 0;
            ack_pe    = ($urandom % 25 == 0) ? 4'(14 + $urandom % 2) : 4'($urandom % NPE);
            #1;
            checks++;
            if (!rst && req_ready !== m_ready()) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, m_ready());
            end
            step();
            checks++;
            if (out_valid !== m_ov || out_pe !== 4'(m_pe) || out_inst !== m_inst) begin
                errors++;
                $display("FAIL rnd_out c=%0d got=%b/%0d/%h exp=%b/%0d/%h",
                         c, out_valid, out_pe, out_inst, m_ov, m_pe, m_inst);
            end
            checks++;
            if (idle !== m_idle() || ack_err !== m_err) begin
                errors++;
                $display("FAIL rnd_flags c=%0d got=%b/%b exp=%b/%b",
                         c, idle, ack_err, m_idle(), m_err);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_inst  = '0;
        ack_valid = 1'b0;
        ack_pe    = '0;
        out_ready = 1'b1;
        m_reset();
        #2;
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_stall();
        test_same_cycle();
        test_illegal_ack();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_dispatch_scheduler.md
# pe_dispatch_scheduler

Clocked scheduler that shares the single packetizer path between the 14 per-PE instruction FIFOs. It issues each instruction only when the target PE has a free slot. The block keeps a credit counter per PE, decremented on every dispatch and replenished by PE ack tokens (the per-PE ack strobes produced by instruction decoding). Among eligible FIFOs it grants round-robin, and registers the winner into a one-entry output stage toward the packetizer.

## Interface
- NUM_PE, 14, number of PE instruction FIFOs / ack sources (≤16)
- INST_W, 16, instruction word width
- MAX_CRED, 2, outstanding instructions allowed per PE (1..7)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- req_valid  input  NUM_PE  FIFO i has an instruction at its head
- req_inst  input  NUM_PE*INST_W  head instruction of FIFO i, slice [i*INST_W +: INST_W]
- req_ready  output  NUM_PE  one-hot grant; FIFO i pops when req_valid[i] && req_ready[i]
- ack_valid  input  1  PE ack token present
- ack_pe  input  4  PE index of the ack
- out_valid  output  1  dispatch register holds an instruction
- out_inst  output  INST_W  instruction to packetizer
- out_pe  output  4  destination PE index
- out_ready  input  1  packetizer accepts when out_valid && out_ready
- idle  output  1  all credits at MAX_CRED and out_valid low
- ack_err  output  1  sticky: illegal ack seen

## Operation
- State: cred[i] (3 bits, per PE), rr_ptr (4 bits), output register {out_valid, out_inst, out_pe}, ack_err.
- Eligible[i] = req_valid[i] && cred[i] != 0.
- Slot free = !out_valid || out_ready.
- Grant: if slot free and any eligible, pick the first eligible index scanning rr_ptr, rr_ptr+1, …, NUM_PE-1, 0, …, wrapping mod NUM_PE. Assert req_ready for that index only; otherwise req_ready = 0.
- On grant to w:
  - Load out_inst ← req_inst slice w, out_pe ← w, out_valid ← 1.
  - rr_ptr ← (w+1) mod NUM_PE.
  - cred[w] decrements.
- Slot free, no grant: out_valid ← 0 if out_ready consumed it, otherwise held.
- Stall (out_valid && !out_ready): out_* held stable and unchanged; no grant; rr_ptr held.
- Ack: if ack_valid && ack_pe < NUM_PE && cred[ack_pe] < MAX_CRED, cred[ack_pe] increments.
- Illegal ack: if ack_pe ≥ NUM_PE, or credit is already at MAX_CRED, no credit change and ack_err ← 1. ack_err clears only on rst.
- Grant and ack to the same PE in one cycle: cred unchanged. A grant never uses a credit returned in that same cycle, because eligibility is evaluated on the registered cred.
- The ack input is always accepted; there is no backpressure on acks.

## Timing
- Reset values:
  - req_ready = 0, out_valid = 0, out_inst = 0, out_pe = 0, ack_err = 0, idle = 1.
  - cred[i] = MAX_CRED, rr_ptr = 0.
- req_ready is combinational from registered state, req_valid and out_ready. There is no combinational path from ack_* to req_ready.
- Latency: req_valid high at edge N with slot free → out_valid high after edge N+1.
- Throughput: one dispatch per cycle while out_ready stays high.
- Credit restored by an ack at edge N is usable for a grant in the cycle after edge N+1.
- rst asserted mid-operation: everything returns to reset values at that edge. The instruction in the output register is dropped, and all credits return to MAX_CRED.
- idle is registered-state combinational: idle = (&all cred == MAX_CRED) && !out_valid.

## Structure
- Shared package (pe_sched_pkg): NUM_PE, PE_IDX_W = 4, INST_W, MAX_CRED, and a typedef pe_idx_t.
- One sub-module: rr_arbiter (NUM_PE requests + pointer → one-hot grant + encoded index, purely combinational).
- Credit counters and output register live in the top.

## Test plan
- Reset, then all 14 req_valid high, out_ready = 1 → grants PE0,1,…,13,0,1,…13 on consecutive cycles. After 28 grants, req_ready = 0 (all credits 0), idle = 0.
- Only PE5 requesting, MAX_CRED = 2, no acks → exactly 2 dispatches with out_pe = 5, then req_ready[5] stays 0. One ack_pe = 5 → one more dispatch 2 cycles later.
- out_ready held low 5 cycles with out_valid = 1, out_inst = 0xA5A5 → out_* stable, no req_ready, rr_ptr unchanged. Release → next grant proceeds from the old pointer.
- Same-cycle grant to PE3 and ack_pe = 3 with cred[3] = 1 → cred[3] stays 1.
- Illegal acks:
  - ack_pe = 14 → ack_err = 1, no credit change.
  - ack to PE with full credit → ack_err = 1, cred remains MAX_CRED.
- rst pulse while out_valid = 1 and cred[7] = 0 → next cycle out_valid = 0, cred[7] = MAX_CRED, rr_ptr = 0, idle = 1, ack_err = 0.
